// File: rtl/icache_fill.sv
// icache_fill: reads one cache line from a QPI flash on a miss, then streams it
// into the icache as an uninterrupted burst of nibble writes.
module icache_fill #(
   parameter int PA = 22,
   parameter int LINE_LENGTH = 4,
   parameter int DUMMY = 6,
   parameter logic [7:0] CMD = 8'hEB,
   localparam int LB = $clog2(LINE_LENGTH),
   localparam int NNIB = 2 * LINE_LENGTH,
   localparam int W = LINE_LENGTH * 8
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic pull,
   input  logic [PA-LB-1:0] tag,
   input  logic flush_all,
   output logic [3:0] dread,
   output logic wstrobe_d,
   output logic busy,
   output logic qspi_cs,
   output logic qspi_sclk,
   output logic [3:0] qspi_out,
   output logic [3:0] qspi_oe,
   input  logic [3:0] qspi_in
);
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_GAP, ST_WRITE} state_t;
   state_t st, st_n;
   logic ph, ph_n, kill, cond, go, last, ser, ser_n;
   logic [7:0] cnt, cnt_n, lim;
   logic [PA-LB-1:0] ltag;
   logic [W-1:0] line;
   logic [23:0] addr24;
   logic [2:0] an;
   logic [LB:0] dn;
   assign ser = st inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
   assign ser_n = st_n inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
   assign lim = st == ST_CMD || st == ST_GAP ? 8'd1 : st == ST_ADDR ? 8'd5 :
                st == ST_DUMMY ? 8'(DUMMY - 1) : 8'(NNIB - 1);
   assign last = cnt == lim;
   assign cond = flush_all || !pull || tag != ltag;
   // The GAP exit also honours a cancel seen in its own final cycle.
   assign go = !kill && !cond;
   assign addr24 = 24'({ltag, {LB{1'b0}}});
   assign an = 3'd5 - cnt_n[2:0];
   assign dn = (LB+1)'(NNIB - 1) - cnt_n[LB:0];
   // Serial states advance once per two-clock slot; GAP and WRITE advance every clock.
   always_comb begin
      st_n = st;
      cnt_n = cnt;
      ph_n = st == ST_IDLE ? 1'b0 : ~ph;
      if (st == ST_IDLE) st_n = req && pull ? ST_CMD : ST_IDLE;
      else if (!ser || ph) begin
         cnt_n = last ? 8'd0 : cnt + 8'd1;
         if (last) st_n = st == ST_CMD ? ST_ADDR : st == ST_ADDR ? ST_DUMMY : st == ST_DUMMY ? ST_DATA :
                          st == ST_DATA ? ST_GAP : st == ST_GAP && go ? ST_WRITE : ST_IDLE;
      end
   end
   // Outputs are registered from the next state so each one lines up with its cycle.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= ST_IDLE;
         ph <= 1'b0;
         cnt <= 8'd0;
         ltag <= '0;
         kill <= 1'b0;
         line <= '0;
         qspi_cs <= 1'b1;
         qspi_sclk <= 1'b0;
         qspi_oe <= 4'h0;
         qspi_out <= 4'h0;
         busy <= 1'b0;
         wstrobe_d <= 1'b0;
         dread <= 4'h0;
      end else begin
         st <= st_n;
         ph <= ph_n;
         cnt <= cnt_n;
         if (st == ST_IDLE && req && pull) begin
            ltag <= tag;
            kill <= 1'b0;
         end else if (st != ST_IDLE && st != ST_WRITE && cond) kill <= 1'b1;
         if (st == ST_DATA && ph) line <= {line[W-5:0], qspi_in};
         qspi_cs <= !ser_n;
         qspi_sclk <= ser_n && ph_n;
         qspi_oe <= st_n == ST_CMD || st_n == ST_ADDR ? 4'hF : 4'h0;
         qspi_out <= st_n == ST_CMD ? (cnt_n[0] ? CMD[3:0] : CMD[7:4]) :
                     st_n == ST_ADDR ? addr24[4*an +: 4] : 4'h0;
         busy <= st_n != ST_IDLE;
         wstrobe_d <= st_n == ST_WRITE;
         dread <= st_n == ST_WRITE ? line[4*dn +: 4] : 4'h0;
      end
endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: directed fills checked cycle by cycle against a timeline model
// of the fill, with a small QPI flash model supplying line data.
`timescale 1ns/1ps
module tb_icache_fill;
   localparam logic [7:0] CMDB = 8'hEB;
   logic clk = 1'b0, reset = 1'b1, req = 1'b0, pull = 1'b0, flush_all = 1'b0;
   logic [19:0] tag = '0;
   logic [3:0] dread, qspi_out, qspi_oe;
   logic [3:0] qspi_in = 4'h0;
   logic wstrobe_d, busy, qspi_cs, qspi_sclk;
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;

   icache_fill dut (
      .clk(clk), .reset(reset), .req(req), .pull(pull), .tag(tag), .flush_all(flush_all),
      .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy), .qspi_cs(qspi_cs),
      .qspi_sclk(qspi_sclk), .qspi_out(qspi_out), .qspi_oe(qspi_oe), .qspi_in(qspi_in)
   );

   function automatic logic [31:0] flash_word(input logic [23:0] a);
      return a == 24'h000048 ? 32'hA1B2C3D4 : {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Flash: latches command+address, then serves the addressed line one nibble per slot.
   int rises = 0;
   logic [31:0] rx = '0, fword;
   always @(posedge qspi_sclk or negedge qspi_cs)
      if (!qspi_sclk) rises = 0;
      else begin
         if (rises < 8) rx = {rx[27:0], qspi_out};
         rises++;
         if (rises >= 15 && rises <= 22) begin
            fword = flash_word(rx[23:0]);
            qspi_in = fword[31-4*(rises-15) -: 4];
         end
      end

   // Model: m_t is the cycle number within the current fill, 0 when idle.
   int m_t = 0;
   bit m_kill = 0;
   logic [19:0] m_tag = '0;
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_t = 0;
         m_kill = 0;
      end else if (m_t == 0) begin
         if (req && pull) begin
            m_t = 1;
            m_tag = tag;
            m_kill = 0;
         end
      end else begin
         if (m_t <= 46 && (flush_all || !pull || tag != m_tag)) m_kill = 1;
         m_t = (m_t == 46 && m_kill) || m_t == 54 ? 0 : m_t + 1;
      end

   always @(negedge clk) begin : cmp
      logic [31:0] seq, fw;
      logic ser, wr;
      logic [3:0] eo, ed;
      if (!reset) begin
         ser = m_t >= 1 && m_t <= 44;
         wr = m_t >= 47 && m_t <= 54;
         seq = {CMDB, 2'b00, m_tag, 2'b00};
         fw = flash_word({2'b00, m_tag, 2'b00});
         eo = 4'h0;
         ed = 4'h0;
         if (m_t >= 1 && m_t <= 16) eo = seq[31-4*((m_t-1)/2) -: 4];
         if (wr) ed = fw[31-4*(m_t-47) -: 4];
         chk("qspi_cs", 32'(qspi_cs), 32'(!ser));
         chk("busy", 32'(busy), 32'(m_t != 0));
         chk("qspi_sclk", 32'(qspi_sclk), 32'(ser && m_t % 2 == 0));
         chk("qspi_oe", 32'(qspi_oe), m_t >= 1 && m_t <= 16 ? 32'hF : 32'h0);
         chk("qspi_out", 32'(qspi_out), 32'(eo));
         chk("wstrobe_d", 32'(wstrobe_d), 32'(wr));
         chk("dread", 32'(dread), 32'(ed));
      end
   end

   // Running tallies; the stimulus takes differences across each fill.
   int cs_low = 0, stb = 0, busy_n = 0;
   logic [31:0] cap = '0;
   always @(negedge clk) begin
      if (!qspi_cs) cs_low++;
      if (busy) busy_n++;
      if (wstrobe_d) begin
         stb++;
         cap = {cap[27:0], dread};
      end
   end

   int c0 = 0, s0 = 0, b0 = 0;
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic start(input logic [19:0] t);
      req = 1'b1;
      pull = 1'b1;
      tag = t;
      c0 = cs_low;
      s0 = stb;
      b0 = busy_n;
      tick(1);
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick(1);
         n++;
      end
      chk("busy_timeout", 32'(busy), 32'h0);
   endtask
   task automatic fill_ok(input string nm, input logic [19:0] t);
      chk({nm, "_cs_low"}, 32'(cs_low - c0), 32'd44);
      chk({nm, "_strobes"}, 32'(stb - s0), 32'd8);
      chk({nm, "_line"}, cap, flash_word({2'b00, t, 2'b00}));
   endtask

   initial begin
      tick(2);
      chk("rst_cs", 32'(qspi_cs), 32'h1);
      chk("rst_sclk", 32'(qspi_sclk), 32'h0);
      chk("rst_oe", 32'(qspi_oe), 32'h0);
      chk("rst_out", 32'(qspi_out), 32'h0);
      chk("rst_dread", 32'(dread), 32'h0);
      chk("rst_wstrobe", 32'(wstrobe_d), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      tick(2);
      // Basic fill, pinned with hand-computed values.
      start(20'h00012);
      wait_idle();
      pull = 1'b0;
      req = 1'b0;
      chk("t1_cs_low", 32'(cs_low - c0), 32'd44);
      chk("t1_busy_cycles", 32'(busy_n - b0), 32'd54);
      chk("t1_strobes", 32'(stb - s0), 32'd8);
      chk("t1_cmd_addr", rx, 32'hEB000048);
      chk("t1_line", cap, 32'hA1B2C3D4);
      chk("t1_rdata_lo", 32'({cap[23:16], cap[31:24]}), 32'h0000B2A1);
      chk("t1_rdata_hi", 32'({cap[7:0], cap[15:8]}), 32'h0000D4C3);
      // flush_all during DATA: full serial sequence, no strobes, busy falls at cycle 47.
      tick(3);
      start(20'h00100);
      tick(35);
      flush_all = 1'b1;
      tick(1);
      flush_all = 1'b0;
      wait_idle();
      pull = 1'b0;
      req = 1'b0;
      chk("t2_cs_low", 32'(cs_low - c0), 32'd44);
      chk("t2_busy_cycles", 32'(busy_n - b0), 32'd46);
      chk("t2_strobes", 32'(stb - s0), 32'd0);
      // Tag change during ADDR, then the still-pending miss refetches the new tag.
      tick(3);
      start(20'h00200);
      tick(8);
      tag = 20'h00300;
      wait_idle();
      chk("t3_cs_low", 32'(cs_low - c0), 32'd44);
      chk("t3_strobes", 32'(stb - s0), 32'd0);
      start(20'h00300);
      wait_idle();
      pull = 1'b0;
      req = 1'b0;
      fill_ok("t3_refetch", 20'h00300);
      chk("t3_cmd_addr", rx, 32'hEB000C00);
      // Back-to-back misses on different tags.
      tick(3);
      start(20'h0ABCD);
      wait_idle();
      fill_ok("t4_first", 20'h0ABCD);
      start(20'h01234);
      wait_idle();
      pull = 1'b0;
      req = 1'b0;
      fill_ok("t4_second", 20'h01234);
      // Asynchronous reset during DATA, then a fresh fill.
      tick(3);
      start(20'h00055);
      tick(30);
      #1 reset = 1'b1;
      #1;
      chk("t5_async_cs", 32'(qspi_cs), 32'h1);
      chk("t5_async_wstrobe", 32'(wstrobe_d), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h0);
      chk("t5_async_sclk", 32'(qspi_sclk), 32'h0);
      pull = 1'b0;
      req = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);
      start(20'h00066);
      wait_idle();
      pull = 1'b0;
      req = 1'b0;
      fill_ok("t5_after", 20'h00066);
      // pull without req never starts a fill.
      tick(3);
      c0 = cs_low;
      b0 = busy_n;
      pull = 1'b1;
      tick(100);
      pull = 1'b0;
      chk("t6_cs_low", 32'(cs_low - c0), 32'd0);
      chk("t6_busy_cycles", 32'(busy_n - b0), 32'd0);
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
